// File: rtl/uart_duplex.sv
// uart_duplex: 8-bit UART transmitter and receiver joined by an internal
// loopback line, with independent baud dividers and power gating per half.
module uart_duplex #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  input  logic [1:0] baud_rate,
  input  logic       power_enable,
  input  logic       tx_enable,
  input  logic       rx_enable,
  input  logic [1:0] power_mode,
  output logic       tx_active_flag,
  output logic       tx_done_flag,
  output logic       rx_active_flag,
  output logic       rx_done_flag,
  output logic [2:0] error_flag,
  output logic [7:0] data_out,
  output logic       power_good,
  output logic [1:0] current_power_mode,
  output logic       tx_clk_enable,
  output logic       rx_clk_enable
);

  // Rounded divisor CLK_HZ / (OVERSAMPLE * baud) for each rate.
  localparam int DIV0 = (CLK_HZ + OVERSAMPLE * 1200) / (OVERSAMPLE * 2400);
  localparam int DIV1 = (CLK_HZ + OVERSAMPLE * 2400) / (OVERSAMPLE * 4800);
  localparam int DIV2 = (CLK_HZ + OVERSAMPLE * 4800) / (OVERSAMPLE * 9600);
  localparam int DIV3 = (CLK_HZ + OVERSAMPLE * 9600) / (OVERSAMPLE * 19200);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic             data_tx_w;
  logic [31:0]      div_sel;
  logic [1:0]       half_en, baud_tick, baud_q;
  logic [1:0][31:0] baud_cnt;

  state_t     tx_state, tx_state_nx;
  logic [3:0] tx_tick, tx_tick_nx;
  logic [2:0] tx_bit, tx_bit_nx;
  logic [7:0] tx_data, tx_data_nx;
  logic [1:0] tx_par, tx_par_nx;
  logic       tx_line, tx_line_nx, tx_done_nx, send_q, send_rise;

  state_t     rx_state, rx_state_nx;
  logic [3:0] rx_tick, rx_tick_nx;
  logic [2:0] rx_bit, rx_bit_nx;
  logic [7:0] rx_shift, rx_shift_nx, data_out_nx;
  logic [1:0] rx_par, rx_par_nx;
  logic [2:0] error_nx;
  logic       rx_perr, rx_perr_nx, rx_done_nx, line_q;

  assign power_good     = power_enable & (current_power_mode != 2'b11);
  assign tx_clk_enable  = power_good & tx_enable & (current_power_mode != 2'b10);
  assign rx_clk_enable  = power_good & rx_enable & (current_power_mode != 2'b10);
  assign half_en        = {rx_clk_enable, tx_clk_enable};
  assign data_tx_w      = tx_line;
  assign send_rise      = send & ~send_q;
  assign tx_active_flag = (tx_state != S_IDLE);
  assign rx_active_flag = (rx_state != S_IDLE);

  // Power mode takes effect one clock after the request.
  always_ff @(posedge clock) begin
    if (reset_n) current_power_mode <= 2'b00;
    else         current_power_mode <= power_mode;
  end

  // Divisor select and per-half tick decode (index 0 = TX, 1 = RX).
  always_comb begin
    case (baud_rate)
      2'b00:   div_sel = 32'(DIV0);
      2'b01:   div_sel = 32'(DIV1);
      2'b10:   div_sel = 32'(DIV2);
      default: div_sel = 32'(DIV3);
    endcase
    for (int h = 0; h < 2; h++)
      baud_tick[h] = half_en[h] && (baud_rate == baud_q) && (baud_cnt[h] == div_sel - 32'd1);
  end

  // Dividers count only while their half is enabled; a rate change restarts both.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      baud_cnt <= '0;
      baud_q   <= '0;
    end else begin
      baud_q <= baud_rate;
      for (int h = 0; h < 2; h++)
        if (!half_en[h] || baud_rate != baud_q || baud_tick[h]) baud_cnt[h] <= '0;
        else                                                    baud_cnt[h] <= baud_cnt[h] + 32'd1;
    end
  end

  // TX next state; line level is derived from the next state so the start
  // bit appears on the same edge that leaves IDLE.
  always_comb begin
    tx_state_nx = tx_state;
    tx_tick_nx  = tx_tick;
    tx_bit_nx   = tx_bit;
    tx_data_nx  = tx_data;
    tx_par_nx   = tx_par;
    tx_done_nx  = 1'b0;
    if (!tx_clk_enable) begin
      tx_state_nx = S_IDLE;
    end else if (tx_state == S_IDLE) begin
      if (send_rise) begin
        tx_state_nx = S_START;
        tx_tick_nx  = '0;
        tx_bit_nx   = '0;
        tx_data_nx  = data_in;
        tx_par_nx   = parity_type;
      end
    end else if (baud_tick[0]) begin
      tx_tick_nx = tx_tick + 4'd1;
      if (tx_tick == 4'd15) begin
        case (tx_state)
          S_START:  tx_state_nx = S_DATA;
          S_DATA:   if (tx_bit == 3'd7) tx_state_nx = (^tx_par) ? S_PARITY : S_STOP;
                    else                tx_bit_nx   = tx_bit + 3'd1;
          S_PARITY: tx_state_nx = S_STOP;
          default: begin
            tx_state_nx = S_IDLE;
            tx_done_nx  = 1'b1;
          end
        endcase
      end
    end
    case (tx_state_nx)
      S_START:  tx_line_nx = 1'b0;
      S_DATA:   tx_line_nx = tx_data_nx[tx_bit_nx];
      S_PARITY: tx_line_nx = (^tx_data_nx) ^ tx_par_nx[0];
      default:  tx_line_nx = 1'b1;
    endcase
  end

  // TX state register.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      tx_state     <= S_IDLE;
      tx_tick      <= '0;
      tx_bit       <= '0;
      tx_data      <= '0;
      tx_par       <= '0;
      tx_line      <= 1'b1;
      tx_done_flag <= 1'b0;
      send_q       <= 1'b0;
    end else begin
      tx_state     <= tx_state_nx;
      tx_tick      <= tx_tick_nx;
      tx_bit       <= tx_bit_nx;
      tx_data      <= tx_data_nx;
      tx_par       <= tx_par_nx;
      tx_line      <= tx_line_nx;
      tx_done_flag <= tx_done_nx;
      send_q       <= send;
    end
  end

  // RX next state: every bit is sampled on its 8th tick; the frame result
  // is published at the stop-bit sample.
  always_comb begin
    rx_state_nx = rx_state;
    rx_tick_nx  = rx_tick;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_par_nx   = rx_par;
    rx_perr_nx  = rx_perr;
    data_out_nx = data_out;
    error_nx    = error_flag;
    rx_done_nx  = 1'b0;
    if (!rx_clk_enable) begin
      rx_state_nx = S_IDLE;
    end else if (rx_state == S_IDLE) begin
      if (line_q && !data_tx_w) begin
        rx_state_nx = S_START;
        rx_tick_nx  = '0;
        rx_bit_nx   = '0;
        rx_par_nx   = parity_type;
        rx_perr_nx  = 1'b0;
      end
    end else if (baud_tick[1]) begin
      rx_tick_nx = rx_tick + 4'd1;
      case (rx_state)
        S_START: begin
          if (rx_tick == 4'd7 && data_tx_w) begin
            rx_state_nx = S_IDLE;
            error_nx    = 3'b010;
            rx_done_nx  = 1'b1;
          end else if (rx_tick == 4'd15) rx_state_nx = S_DATA;
        end
        S_DATA: begin
          if (rx_tick == 4'd7) rx_shift_nx = {data_tx_w, rx_shift[7:1]};
          if (rx_tick == 4'd15) begin
            if (rx_bit == 3'd7) rx_state_nx = (^rx_par) ? S_PARITY : S_STOP;
            else                rx_bit_nx   = rx_bit + 3'd1;
          end
        end
        S_PARITY: begin
          if (rx_tick == 4'd7)  rx_perr_nx  = data_tx_w != ((^rx_shift) ^ rx_par[0]);
          if (rx_tick == 4'd15) rx_state_nx = S_STOP;
        end
        default: begin
          if (rx_tick == 4'd7) begin
            rx_state_nx = S_IDLE;
            data_out_nx = rx_shift;
            error_nx    = {~data_tx_w, 1'b0, rx_perr};
            rx_done_nx  = 1'b1;
          end
        end
      endcase
    end
  end

  // RX state register and result outputs.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      rx_state     <= S_IDLE;
      rx_tick      <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_par       <= '0;
      rx_perr      <= 1'b0;
      data_out     <= '0;
      error_flag   <= '0;
      rx_done_flag <= 1'b0;
      line_q       <= 1'b1;
    end else begin
      rx_state     <= rx_state_nx;
      rx_tick      <= rx_tick_nx;
      rx_bit       <= rx_bit_nx;
      rx_shift     <= rx_shift_nx;
      rx_par       <= rx_par_nx;
      rx_perr      <= rx_perr_nx;
      data_out     <= data_out_nx;
      error_flag   <= error_nx;
      rx_done_flag <= rx_done_nx;
      line_q       <= data_tx_w;
    end
  end

endmodule

// File: tb/tb_uart_duplex.sv
// Testbench for uart_duplex: loopback frames at every rate and parity,
// gating, reset, power modes and line fault injection, checked against a
// frame-level model of the serial protocol.
`timescale 1ns/1ps
module tb_uart_duplex;
  // Scaled clock so divisors are 8/4/2/1 and frames stay short.
  localparam int CLK_HZ = 307_200;

  logic clock_tb = 1'b0;
  always #5 clock_tb = ~clock_tb;

  logic       reset_n, send, power_enable, tx_enable, rx_enable;
  logic [7:0] data_in, data_out;
  logic [1:0] parity_type, baud_rate, power_mode, current_power_mode;
  logic       tx_active_flag, tx_done_flag, rx_active_flag, rx_done_flag;
  logic       power_good, tx_clk_enable, rx_clk_enable;
  logic [2:0] error_flag;

  uart_duplex #(.CLK_HZ(CLK_HZ), .OVERSAMPLE(16)) dut (
    .clock(clock_tb), .reset_n(reset_n), .send(send), .data_in(data_in),
    .parity_type(parity_type), .baud_rate(baud_rate), .power_enable(power_enable),
    .tx_enable(tx_enable), .rx_enable(rx_enable), .power_mode(power_mode),
    .tx_active_flag(tx_active_flag), .tx_done_flag(tx_done_flag),
    .rx_active_flag(rx_active_flag), .rx_done_flag(rx_done_flag),
    .error_flag(error_flag), .data_out(data_out), .power_good(power_good),
    .current_power_mode(current_power_mode), .tx_clk_enable(tx_clk_enable),
    .rx_clk_enable(rx_clk_enable)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0, rx_done_cnt = 0, tx_done_cnt = 0, rx_done_cyc = 0, tx_done_cyc = 0;

  always @(posedge clock_tb) cyc <= cyc + 1;

  always @(negedge clock_tb) begin
    if (rx_done_flag) begin rx_done_cnt <= rx_done_cnt + 1; rx_done_cyc <= cyc; end
    if (tx_done_flag) begin tx_done_cnt <= tx_done_cnt + 1; tx_done_cyc <= cyc; end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d want < 80000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef bit bitq_t[$];
  int bauds[4] = '{2400, 4800, 9600, 19200};

  function automatic int div_of(input logic [1:0] b);
    return $rtoi(real'(CLK_HZ) / (16.0 * real'(bauds[b])) + 0.5);
  endfunction

  function automatic bit par_on(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  function automatic int ones(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  // Serial frame as a list of line levels, one per bit period.
  function automatic bitq_t build_frame(input logic [7:0] d, input logic [1:0] p);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (p == 2'b01) q.push_back((ones(d) % 2) == 0);
    if (p == 2'b10) q.push_back((ones(d) % 2) == 1);
    q.push_back(1'b1);
    return q;
  endfunction

  // What a receiver should report for a given sequence of line levels:
  // {error[2:0], data[7:0]}.
  function automatic logic [10:0] decode(input bitq_t q, input logic [1:0] p);
    logic [7:0] d;
    logic perr, serr;
    int n1;
    for (int i = 0; i < 8; i++) d[i] = q[1 + i];
    perr = 1'b0;
    if (par_on(p)) begin
      n1   = ones(d) + int'(q[9]);
      perr = (p == 2'b01) ? ((n1 % 2) == 0) : ((n1 % 2) == 1);
    end
    serr = (q[q.size() - 1] == 1'b0);
    return {serr, 1'b0, perr, d};
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clock_tb); #1; end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clock_tb); #1;
    reset_n = 1'b1;
    repeat (cycles) @(posedge clock_tb);
    #1;
    reset_n = 1'b0;
  endtask

  // Send one frame, optionally overriding one bit period on the line, and
  // check line levels, frame length, done pulses and the received result.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b,
                           input int inj_bit, input bit inj_val, input bit expect_rx,
                           input bit hold_send, input string tag);
    bitq_t q, rq;
    logic [10:0] exp;
    logic [7:0] prev_out;
    int dv, bt, t0, n, rx0, tx0;
    bit got;
    q = build_frame(d, p);
    rq = q;
    if (inj_bit >= 0) rq[inj_bit] = inj_val;
    exp = decode(rq, p);
    n = q.size(); dv = div_of(b); bt = 16 * dv;
    prev_out = data_out; rx0 = rx_done_cnt; tx0 = tx_done_cnt;
    data_in = d; parity_type = p; baud_rate = b;
    repeat (4) @(posedge clock_tb);
    #1;
    send = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clock_tb); #1;
      if (dut.data_tx_w === 1'b0) got = 1'b1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s start: line got %b want 0 within 8 clocks of send", tag, dut.data_tx_w);
      send = 1'b0;
      return;
    end
    t0 = cyc;
    n_checks++;
    if (tx_active_flag !== 1'b1) begin
      n_fail++; $display("FAIL %s tx_active: got %b want 1", tag, tx_active_flag);
    end
    if (!hold_send) send = 1'b0;
    for (int k = 0; k < n; k++) begin
      wait_cyc(t0 + k * bt + bt / 4);
      if (k == inj_bit) begin
        if (inj_val) force dut.data_tx_w = 1'b1;
        else         force dut.data_tx_w = 1'b0;
      end
      wait_cyc(t0 + k * bt + bt / 2);
      if (k != inj_bit) begin
        n_checks++;
        if (dut.data_tx_w !== q[k]) begin
          n_fail++; $display("FAIL %s line bit %0d: got %b want %b", tag, k, dut.data_tx_w, q[k]);
        end
      end
      wait_cyc(t0 + k * bt + 3 * bt / 4);
      if (k == inj_bit) release dut.data_tx_w;
    end
    for (int i = 0; i < 2 * bt && tx_done_cnt == tx0; i++) begin @(posedge clock_tb); #1; end
    @(posedge clock_tb); #1;
    n_checks++;
    if (tx_done_cnt !== tx0 + 1) begin
      n_fail++; $display("FAIL %s tx_done pulses: got %0d want 1", tag, tx_done_cnt - tx0);
    end
    n_checks++;
    if (tx_done_cyc - t0 < n * bt - dv || tx_done_cyc - t0 > n * bt + 1) begin
      n_fail++; $display("FAIL %s frame length: got %0d clocks want %0d (-%0d/+1)", tag, tx_done_cyc - t0, n * bt, dv);
    end
    if (expect_rx) begin
      n_checks++;
      if (rx_done_cnt !== rx0 + 1) begin
        n_fail++; $display("FAIL %s rx_done pulses: got %0d want 1", tag, rx_done_cnt - rx0);
      end
      n_checks++;
      if (rx_done_cyc > t0 + n * bt) begin
        n_fail++; $display("FAIL %s rx_done timing: got clock %0d want <= %0d", tag, rx_done_cyc, t0 + n * bt);
      end
      n_checks++;
      if (data_out !== exp[7:0]) begin
        n_fail++; $display("FAIL %s data_out: got %h want %h", tag, data_out, exp[7:0]);
      end
      n_checks++;
      if (error_flag !== exp[10:8]) begin
        n_fail++; $display("FAIL %s error_flag: got %b want %b", tag, error_flag, exp[10:8]);
      end
    end else begin
      n_checks++;
      if (rx_done_cnt !== rx0) begin
        n_fail++; $display("FAIL %s gated rx_done pulses: got %0d want 0", tag, rx_done_cnt - rx0);
      end
      n_checks++;
      if (data_out !== prev_out) begin
        n_fail++; $display("FAIL %s gated data_out: got %h want %h", tag, data_out, prev_out);
      end
    end
    if (hold_send) begin
      repeat (2 * bt) @(posedge clock_tb);
      #1;
      n_checks++;
      if (tx_active_flag !== 1'b0 || tx_done_cnt !== tx0 + 1) begin
        n_fail++; $display("FAIL %s held send retrigger: got active %b dones %0d want 0 and 1", tag, tx_active_flag, tx_done_cnt - tx0);
      end
      send = 1'b0;
    end
    repeat (bt / 2 + 4) @(posedge clock_tb);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    do_reset(5);
    n_checks++;
    if ({tx_active_flag, tx_done_flag, rx_active_flag, rx_done_flag} !== 4'b0000) begin
      n_fail++; $display("FAIL reset flags: got %b want 0000", {tx_active_flag, tx_done_flag, rx_active_flag, rx_done_flag});
    end
    n_checks++;
    if (data_out !== 8'h00 || error_flag !== 3'b000) begin
      n_fail++; $display("FAIL reset data/err: got %h/%b want 00/000", data_out, error_flag);
    end
    n_checks++;
    if (dut.data_tx_w !== 1'b1) begin
      n_fail++; $display("FAIL reset line: got %b want 1", dut.data_tx_w);
    end
    n_checks++;
    if ({current_power_mode, power_good, tx_clk_enable, rx_clk_enable} !== 5'b00111) begin
      n_fail++; $display("FAIL reset power: got %b want 00111", {current_power_mode, power_good, tx_clk_enable, rx_clk_enable});
    end
  endtask

  task automatic test_basic;
    run_frame(8'hAA, 2'b00, 2'b10, -1, 1'b0, 1'b1, 1'b1, "basic_AA");
  endtask

  task automatic test_parity_frames;
    logic [7:0] d;
    logic [1:0] p, b;
    run_frame(8'h55, 2'b01, 2'b11, -1, 1'b0, 1'b1, 1'b0, "odd_55_19200");
    run_frame(8'hF0, 2'b10, 2'b01, -1, 1'b0, 1'b1, 1'b0, "even_F0_4800");
    run_frame(8'h00, 2'b01, 2'b10, -1, 1'b0, 1'b1, 1'b0, "odd_00_9600");
    run_frame(8'hFF, 2'b10, 2'b10, -1, 1'b0, 1'b1, 1'b0, "even_FF_9600");
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom); p = 2'($urandom_range(0, 3)); b = 2'($urandom_range(0, 3));
      run_frame(d, p, b, -1, 1'b0, 1'b1, 1'b0, "random");
    end
  endtask

  task automatic test_tx_gated;
    int tx0;
    bit bad;
    tx0 = tx_done_cnt; bad = 1'b0;
    baud_rate = 2'b10; tx_enable = 1'b0;
    @(posedge clock_tb); #1;
    send = 1'b1;
    for (int i = 0; i < 2 * 11 * 16 * div_of(2'b10); i++) begin
      @(posedge clock_tb); #1;
      if (i == 4) send = 1'b0;
      if (tx_active_flag !== 1'b0 || dut.data_tx_w !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad || tx_done_cnt !== tx0) begin
      n_fail++; $display("FAIL tx_gated: got activity %b dones %0d want 0 and 0", bad, tx_done_cnt - tx0);
    end
    tx_enable = 1'b1;
    repeat (4) @(posedge clock_tb);
    #1;
  endtask

  task automatic test_rx_gated;
    rx_enable = 1'b0;
    run_frame(8'hAD, 2'b00, 2'b10, -1, 1'b0, 1'b0, 1'b0, "rx_gated_AD");
    rx_enable = 1'b1;
    run_frame(8'($urandom), 2'b10, 2'b10, -1, 1'b0, 1'b1, 1'b0, "rx_reenabled");
  endtask

  task automatic test_reset_mid_frame;
    int rx0, tx0, bt;
    bt = 16 * div_of(2'b10);
    rx0 = rx_done_cnt; tx0 = tx_done_cnt;
    data_in = 8'h3C; parity_type = 2'b00; baud_rate = 2'b10;
    @(posedge clock_tb); #1;
    send = 1'b1;
    repeat (4 * bt) @(posedge clock_tb);
    #1;
    send = 1'b0;
    n_checks++;
    if (tx_active_flag !== 1'b1 || rx_active_flag !== 1'b1) begin
      n_fail++; $display("FAIL mid_frame busy: got tx %b rx %b want 1 1", tx_active_flag, rx_active_flag);
    end
    do_reset(50);
    n_checks++;
    if (tx_active_flag !== 1'b0 || rx_active_flag !== 1'b0 || dut.data_tx_w !== 1'b1) begin
      n_fail++; $display("FAIL mid_frame reset: got tx %b rx %b line %b want 0 0 1", tx_active_flag, rx_active_flag, dut.data_tx_w);
    end
    n_checks++;
    if (data_out !== 8'h00 || error_flag !== 3'b000) begin
      n_fail++; $display("FAIL mid_frame reset data/err: got %h/%b want 00/000", data_out, error_flag);
    end
    repeat (2 * bt) @(posedge clock_tb);
    #1;
    n_checks++;
    if (rx_done_cnt !== rx0 || tx_done_cnt !== tx0) begin
      n_fail++; $display("FAIL mid_frame done pulses: got rx %0d tx %0d want 0 0", rx_done_cnt - rx0, tx_done_cnt - tx0);
    end
    run_frame(8'hBE, 2'b00, 2'b10, -1, 1'b0, 1'b1, 1'b0, "after_reset_BE");
  endtask

  task automatic test_power;
    int rx0, tx0, bt;
    @(posedge clock_tb); #1;
    power_mode = 2'b10;
    #1;
    n_checks++;
    if (current_power_mode !== 2'b00) begin
      n_fail++; $display("FAIL pm latency: got %b want 00", current_power_mode);
    end
    @(posedge clock_tb); #1;
    n_checks++;
    if ({current_power_mode, power_good, tx_clk_enable, rx_clk_enable} !== 5'b10100) begin
      n_fail++; $display("FAIL standby: got %b want 10100", {current_power_mode, power_good, tx_clk_enable, rx_clk_enable});
    end
    power_mode = 2'b11;
    @(posedge clock_tb); #1;
    n_checks++;
    if ({power_good, tx_clk_enable, rx_clk_enable} !== 3'b000) begin
      n_fail++; $display("FAIL off: got %b want 000", {power_good, tx_clk_enable, rx_clk_enable});
    end
    power_mode = 2'b01;
    @(posedge clock_tb); #1;
    n_checks++;
    if ({power_good, tx_clk_enable, rx_clk_enable} !== 3'b111) begin
      n_fail++; $display("FAIL low_power: got %b want 111", {power_good, tx_clk_enable, rx_clk_enable});
    end
    power_enable = 1'b0;
    #1;
    n_checks++;
    if ({power_good, tx_clk_enable, rx_clk_enable} !== 3'b000) begin
      n_fail++; $display("FAIL power_enable off: got %b want 000", {power_good, tx_clk_enable, rx_clk_enable});
    end
    power_enable = 1'b1; power_mode = 2'b00;
    repeat (2) @(posedge clock_tb);
    #1;
    // Standby mid-frame aborts both halves without done pulses.
    bt = 16 * div_of(2'b00);
    rx0 = rx_done_cnt; tx0 = tx_done_cnt;
    data_in = 8'h81; parity_type = 2'b01; baud_rate = 2'b00;
    repeat (2) @(posedge clock_tb);
    #1;
    send = 1'b1;
    repeat (3 * bt) @(posedge clock_tb);
    #1;
    send = 1'b0;
    power_mode = 2'b10;
    repeat (2) @(posedge clock_tb);
    #1;
    n_checks++;
    if (tx_active_flag !== 1'b0 || rx_active_flag !== 1'b0 || dut.data_tx_w !== 1'b1) begin
      n_fail++; $display("FAIL standby abort: got tx %b rx %b line %b want 0 0 1", tx_active_flag, rx_active_flag, dut.data_tx_w);
    end
    repeat (10 * bt) @(posedge clock_tb);
    #1;
    n_checks++;
    if (rx_done_cnt !== rx0 || tx_done_cnt !== tx0) begin
      n_fail++; $display("FAIL standby done pulses: got rx %0d tx %0d want 0 0", rx_done_cnt - rx0, tx_done_cnt - tx0);
    end
    power_mode = 2'b00;
    repeat (4) @(posedge clock_tb);
    #1;
  endtask

  task automatic test_errors;
    bitq_t q;
    logic [7:0] d, prev;
    int rx0, dv;
    d = 8'($urandom);
    q = build_frame(d, 2'b01);
    run_frame(d, 2'b01, 2'b10, 9, ~q[9], 1'b1, 1'b0, "parity_err");
    run_frame(8'($urandom), 2'b00, 2'b10, 9, 1'b0, 1'b1, 1'b0, "stop_err");
    // Short low glitch while idle must be rejected as a bad start bit.
    dv = div_of(2'b10); baud_rate = 2'b10;
    prev = data_out; rx0 = rx_done_cnt;
    repeat (4) @(posedge clock_tb);
    #1;
    force dut.data_tx_w = 1'b0;
    repeat (2 * dv) @(posedge clock_tb);
    #1;
    release dut.data_tx_w;
    repeat (32 * dv) @(posedge clock_tb);
    #1;
    n_checks++;
    if (rx_done_cnt !== rx0 + 1) begin
      n_fail++; $display("FAIL glitch rx_done pulses: got %0d want 1", rx_done_cnt - rx0);
    end
    n_checks++;
    if (error_flag !== 3'b010 || data_out !== prev) begin
      n_fail++; $display("FAIL glitch err/data: got %b/%h want 010/%h", error_flag, data_out, prev);
    end
    run_frame(8'h5A, 2'b10, 2'b10, -1, 1'b0, 1'b1, 1'b0, "after_errors");
  endtask

  initial begin
    reset_n = 1'b1; send = 1'b0; data_in = 8'h00; parity_type = 2'b00; baud_rate = 2'b10;
    power_enable = 1'b1; tx_enable = 1'b1; rx_enable = 1'b1; power_mode = 2'b00;
    test_reset();
    test_basic();
    test_parity_frames();
    test_tx_gated();
    test_rx_gated();
    test_reset_mid_frame();
    test_power();
    test_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
